// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls and taken-branch flushes at the ID/EX boundary,
// with saturating event counters for performance debug.

`ifndef ASIZE
`define ASIZE 5
`endif

module hazard_ctrl #(
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [`ASIZE-1:0] id_rs1,
    input  logic [`ASIZE-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              idex_memtoreg,
    input  logic              idex_writeenable,
    input  logic [`ASIZE-1:0] idex_waddr,
    input  logic              exe_branch_taken,
    input  logic              cnt_clr,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              pc_redirect,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {
        StRun,
        StStall
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic hit;
    logic stall_inc;
    logic flush_inc;
    logic do_stall;
    logic do_flush;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hit = idex_memtoreg & idex_writeenable & (idex_waddr != '0) &
                 ((id_use_rs1 & (id_rs1 == idex_waddr)) |
                  (id_use_rs2 & (id_rs2 == idex_waddr)));

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        do_stall  = 1'b0;
        do_flush  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (exe_branch_taken) begin
                    do_flush = 1'b1;
                end else if (hit) begin
                    do_stall = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        state_d = StStall;
                        rem_d   = 3'(STALL_CYCLES - 1);
                    end
                end
            end
            StStall: begin
                // A branch here means ID/EX was not a bubble; flush wins and the stall is dropped.
                if (exe_branch_taken) begin
                    do_flush = 1'b1;
                    state_d  = StRun;
                    rem_d    = '0;
                end else begin
                    do_stall = 1'b1;
                    rem_d    = rem_q - 3'd1;
                    if (rem_q == 3'd1) begin
                        state_d = StRun;
                    end
                end
            end
            default: begin
                state_d = StRun;
                rem_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pc_redirect = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (rst) begin
            pc_stall    = do_stall;
            ifid_stall  = do_stall;
            ifid_flush  = do_flush;
            idex_bubble = do_stall | do_flush;
            pc_redirect = do_flush;
            stall_inc   = do_stall;
            flush_inc   = do_flush;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StRun;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign busy      = rst & (state_q == StStall);
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: three instances (1-cycle, 3-cycle stall, 4-bit counters)
// share one stimulus stream; expected values are queued per cycle and compared mid-cycle.

`ifndef ASIZE
`define ASIZE 5
`endif

module tb_hazard_ctrl;

    localparam logic [4:0] CTL_NONE  = 5'b00000;
    localparam logic [4:0] CTL_STALL = 5'b11010; // pc_stall ifid_stall - idex_bubble -
    localparam logic [4:0] CTL_FLUSH = 5'b00111; // - - ifid_flush idex_bubble pc_redirect

    logic              clk;
    logic              rst;
    logic [`ASIZE-1:0] id_rs1, id_rs2, idex_waddr;
    logic              id_use_rs1, id_use_rs2, idex_memtoreg, idex_writeenable;
    logic              exe_branch_taken, cnt_clr;

    logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_pc_redirect, a_busy;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_pc_redirect, b_busy;
    logic [15:0] b_stall_cnt, b_flush_cnt;
    logic        c_pc_stall, c_ifid_stall, c_ifid_flush, c_idex_bubble, c_pc_redirect, c_busy;
    logic [3:0]  c_stall_cnt, c_flush_cnt;

    typedef struct {
        string       name;
        int          inst;
        logic [37:0] exp;
    } sb_entry_t;

    sb_entry_t sb[$];
    int checks   = 0;
    int failures = 0;

    hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_memtoreg(idex_memtoreg), .idex_writeenable(idex_writeenable),
        .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken), .cnt_clr(cnt_clr),
        .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall), .ifid_flush(a_ifid_flush),
        .idex_bubble(a_idex_bubble), .pc_redirect(a_pc_redirect), .busy(a_busy),
        .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    hazard_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_memtoreg(idex_memtoreg), .idex_writeenable(idex_writeenable),
        .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken), .cnt_clr(cnt_clr),
        .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall), .ifid_flush(b_ifid_flush),
        .idex_bubble(b_idex_bubble), .pc_redirect(b_pc_redirect), .busy(b_busy),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    hazard_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .idex_memtoreg(idex_memtoreg), .idex_writeenable(idex_writeenable),
        .idex_waddr(idex_waddr), .exe_branch_taken(exe_branch_taken), .cnt_clr(cnt_clr),
        .pc_stall(c_pc_stall), .ifid_stall(c_ifid_stall), .ifid_flush(c_ifid_flush),
        .idex_bubble(c_idex_bubble), .pc_redirect(c_pc_redirect), .busy(c_busy),
        .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [37:0] mk(logic [4:0] ctl, logic bsy, int sc, int fc);
        return {ctl, bsy, 16'(sc), 16'(fc)};
    endfunction

    function automatic logic [37:0] obs(int inst);
        case (inst)
            0: return {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_pc_redirect,
                       a_busy, a_stall_cnt, a_flush_cnt};
            1: return {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_pc_redirect,
                       b_busy, b_stall_cnt, b_flush_cnt};
            default: return {c_pc_stall, c_ifid_stall, c_ifid_flush, c_idex_bubble,
                             c_pc_redirect, c_busy, 12'd0, c_stall_cnt, 12'd0, c_flush_cnt};
        endcase
    endfunction

    task automatic drive(logic mtr, logic we, logic [`ASIZE-1:0] wa, logic [`ASIZE-1:0] r1,
                         logic [`ASIZE-1:0] r2, logic u1, logic u2, logic br, logic clr);
        idex_memtoreg    = mtr;
        idex_writeenable = we;
        idex_waddr       = wa;
        id_rs1           = r1;
        id_rs2           = r2;
        id_use_rs1       = u1;
        id_use_rs2       = u2;
        exe_branch_taken = br;
        cnt_clr          = clr;
    endtask

    task automatic push(string name, int inst, logic [37:0] exp);
        sb_entry_t e;
        e.name = name;
        e.inst = inst;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic reset_all();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        sb_entry_t e;
        logic [37:0] got;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) exe_branch_taken = 1'b1;
            for (int i = 0; i < 3; i++) push("reset", i, mk(CTL_NONE, 0, 0, 0));
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
    endtask

    task automatic test_load_use_sc1();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: begin drive(1, 1, 5, 5, 0, 1, 0, 0, 0); push("lu_rs1", 0, mk(CTL_STALL, 0, 0, 0)); end
                1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("lu_after", 0, mk(CTL_NONE, 0, 1, 0)); end
                2: begin drive(1, 1, 0, 0, 0, 1, 0, 0, 0); push("lu_x0", 0, mk(CTL_NONE, 0, 1, 0)); end
                3: begin drive(1, 1, 7, 0, 7, 0, 1, 0, 0); push("lu_rs2", 0, mk(CTL_STALL, 0, 1, 0)); end
                4: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("lu_rs2_cnt", 0, mk(CTL_NONE, 0, 2, 0)); end
                5: begin drive(1, 0, 7, 7, 0, 1, 0, 0, 0); push("lu_no_we", 0, mk(CTL_NONE, 0, 2, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("lu_idle", 0, mk(CTL_NONE, 0, 2, 0)); end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall3();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 9; k++) begin
            case (k)
                0: begin drive(1, 1, 5, 5, 0, 1, 0, 0, 0); push("s3_hit", 1, mk(CTL_STALL, 0, 0, 0)); end
                1: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("s3_c2", 1, mk(CTL_STALL, 1, 1, 0)); end
                2: push("s3_c3", 1, mk(CTL_STALL, 1, 2, 0));
                3: push("s3_done", 1, mk(CTL_NONE, 0, 3, 0));
                4: push("s3_idle", 1, mk(CTL_NONE, 0, 3, 0));
                5: begin drive(1, 1, 9, 0, 9, 0, 1, 0, 0); push("s3_hit2", 1, mk(CTL_STALL, 0, 3, 0)); end
                6: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                    rst = 1'b0;
                    push("s3_rst_abort", 1, mk(CTL_NONE, 0, 4, 0));
                end
                7: begin rst = 1'b1; push("s3_post_rst", 1, mk(CTL_NONE, 0, 0, 0)); end
                default: push("s3_no_residual", 1, mk(CTL_NONE, 0, 0, 0));
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_simultaneous();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 5; k++) begin
            case (k)
                0: begin
                    drive(1, 1, 5, 5, 0, 1, 0, 1, 0);
                    push("sim_a", 0, mk(CTL_FLUSH, 0, 0, 0));
                    push("sim_b", 1, mk(CTL_FLUSH, 0, 0, 0));
                end
                1: begin
                    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                    push("sim_a_cnt", 0, mk(CTL_NONE, 0, 0, 1));
                    push("sim_b_cnt", 1, mk(CTL_NONE, 0, 0, 1));
                end
                2: begin drive(1, 1, 3, 3, 0, 1, 0, 0, 0); push("stbr_hit", 1, mk(CTL_STALL, 0, 0, 1)); end
                3: begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0); push("stbr_flush", 1, mk(CTL_FLUSH, 1, 1, 1)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("stbr_run", 1, mk(CTL_NONE, 0, 1, 2)); end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_saturation();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 23; k++) begin
            if (k < 20) begin
                drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
                push("sat_flush", 2, mk(CTL_FLUSH, 0, 0, (k < 15) ? k : 15));
            end else if (k == 20) begin
                drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
                push("sat_clr", 2, mk(CTL_FLUSH, 0, 0, 15));
            end else if (k == 21) begin
                drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
                push("sat_cleared", 2, mk(CTL_FLUSH, 0, 0, 0));
            end else begin
                drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
                push("sat_recount", 2, mk(CTL_NONE, 0, 0, 1));
                push("wide_recount", 0, mk(CTL_NONE, 0, 0, 1));
            end
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_no_hazard();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin drive(1, 1, 5, 5, 5, 0, 0, 0, 0); push("nh_unused", 0, mk(CTL_NONE, 0, 0, 0)); end
                1: begin drive(0, 1, 5, 5, 5, 1, 1, 0, 0); push("nh_no_load", 0, mk(CTL_NONE, 0, 0, 0)); end
                2: begin drive(1, 1, 6, 5, 4, 1, 1, 0, 0); push("nh_other_reg", 0, mk(CTL_NONE, 0, 0, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("nh_cnt", 0, mk(CTL_NONE, 0, 0, 0)); end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        sb_entry_t e;
        logic [37:0] got;
        reset_all();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin drive(1, 1, 2, 2, 0, 1, 0, 0, 0); push("b2b_1", 0, mk(CTL_STALL, 0, 0, 0)); end
                1: begin drive(1, 1, 3, 0, 3, 0, 1, 0, 0); push("b2b_2", 0, mk(CTL_STALL, 0, 1, 0)); end
                default: begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); push("b2b_cnt", 0, mk(CTL_NONE, 0, 2, 0)); end
            endcase
            @(negedge clk);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                got = obs(e.inst);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s inst=%0d got=%h exp=%h", e.name, e.inst, got, e.exp);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1, 1, 5, 5, 5, 1, 1, 0, 0);
        test_reset();
        test_load_use_sc1();
        test_stall3();
        test_simultaneous();
        test_saturation();
        test_no_hazard();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller on the consumer side of the ID/EX pipeline register. It compares the instruction currently decoding in ID against the registered ID/EX control outputs and the branch resolution from EXE. It generates the stall, flush and bubble controls for the PC, IF/ID and ID/EX registers. It also keeps saturating event counters for performance debug.

## Interface
Parameters:
- STALL_CYCLES, default 1: bubbles inserted per load-use hazard (data-memory read latency); legal range 1–7.
- CNT_W, default 16: width of each event counter.
- Register-address width is `ASIZE from define.v.

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low (rst==0 resets on posedge clk).
- id_rs1  in  `ASIZE  source register 1 of the instruction in ID.
- id_rs2  in  `ASIZE  source register 2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- idex_memtoreg  in  1  ID/EX memtoreg output (load in EXE).
- idex_writeenable  in  1  ID/EX writeenable output.
- idex_waddr  in  `ASIZE  ID/EX destination register.
- exe_branch_taken  in  1  EXE resolved a taken conditional or unconditional branch this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_stall  out  1  hold PC.
- ifid_stall  out  1  hold IF/ID.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_bubble  out  1  load zeros (NOP, all control 0) into ID/EX on next edge.
- pc_redirect  out  1  select branch target for PC.
- busy  out  1  FSM not in RUN.
- stall_cnt  out  CNT_W  bubble cycles inserted for load-use.
- flush_cnt  out  CNT_W  taken-branch flushes.

## Operation
Definitions:
- hit = idex_memtoreg & idex_writeenable & (idex_waddr != 0) & ((id_use_rs1 & id_rs1 == idex_waddr) | (id_use_rs2 & id_rs2 == idex_waddr)).
- Register 0 never causes a hazard.

FSM states and transitions:
- RUN:
  - exe_branch_taken=1: ifid_flush=1, idex_bubble=1, pc_redirect=1, no stall. Stay in RUN. flush_cnt += 1.
  - Else if hit: pc_stall=ifid_stall=idex_bubble=1; stall_cnt += 1. If STALL_CYCLES==1, stay in RUN. Otherwise go to STALL with rem = STALL_CYCLES-1.
  - Else: all outputs 0.
- STALL:
  - Assert pc_stall=ifid_stall=idex_bubble=1 and stall_cnt += 1.
  - rem decrements each cycle. When rem==1 this cycle, return to RUN next cycle.
  - hit is not re-evaluated in STALL; the load has left ID/EX by then.
  - exe_branch_taken in STALL cannot occur, because ID/EX holds a bubble. If it is asserted anyway: treat it as in RUN (flush wins), return to RUN, and do not count a stall that cycle.

Priority: branch flush > load-use stall. The instruction in ID is wrong-path.

Counters: saturate at 2^CNT_W-1. cnt_clr has priority over increment; counters read 0 the cycle after.

Reset:
- While rst==0, all control outputs are forced to 0 combinationally.
- On the edge with rst==0: state←RUN, rem←0, counters←0. busy=0 after reset.
- Reset asserted mid-STALL aborts the stall; no residual bubbles.

## Timing
- Control outputs are combinational from the current state and inputs, valid in the same cycle as the hazard. They are consumed by the PC, IF/ID and ID/EX registers on the next edge.
- Load-use hazard costs exactly STALL_CYCLES cycles of stall plus bubble. The dependent instruction enters ID/EX on the edge after the last stall cycle.
- Taken branch costs 2 cycles: the IF/ID and ID/EX wrong-path instructions are killed on the same edge.
- Counters update on the edge closing the event cycle.
- busy is registered state: 1 for the STALL_CYCLES-1 cycles after a hit cycle.

## Test plan
- Reset: hold rst=0 for 2 cycles with hit conditions driven. Required: all outputs 0, counters 0, busy=0.
- Load-use, STALL_CYCLES=1: idex_memtoreg=1, idex_writeenable=1, idex_waddr=5, id_rs1=5, id_use_rs1=1. Required: one cycle of pc_stall=ifid_stall=idex_bubble=1, stall_cnt=1. Same with idex_waddr=0: no stall.
- STALL_CYCLES=3: a single hit cycle, then inputs cleared. Required: 3 consecutive stall cycles, busy=1 for cycles 2–3, stall_cnt=3. Assert rst=0 in stall cycle 2: outputs 0 immediately, RUN after the edge.
- Simultaneous events: hit=1 and exe_branch_taken=1 in the same cycle. Required: ifid_flush=idex_bubble=pc_redirect=1, pc_stall=0, flush_cnt=1, stall_cnt=0.
- Counter saturation: CNT_W=4, 20 branch flushes. Required: flush_cnt=15. Then cnt_clr=1 together with a flush: flush_cnt=0.
- No hazard: id_use_rs2=0 with id_rs2==idex_waddr, load in EXE. Required: no stall.
